// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and the bit-timing helper
// used identically by uart_tx and uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_t;

    function automatic int cycles_per_bit(input int clock, input int baud);
        return (clock / baud) - 1;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// selectable reset level so an idle-high line reads idle out of reset.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= RST_VAL;
            o_q  <= RST_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the RX line, qualifies the start bit at
// half-bit, samples data LSB-first at mid-bit and checks the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE     = 50000000,
    parameter int BAUD_RATE      = 9600,
    parameter int DATA_BITS      = 8,
    parameter int CYCLES_PER_BIT = cycles_per_bit(CLOCK_RATE, BAUD_RATE)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int HALF  = (CYCLES_PER_BIT + 1) / 2;
    localparam int CNT_W = $clog2(CYCLES_PER_BIT + 1);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_in;
    logic                 rx_s;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    // New bit enters at the MSB so the first (LSB) bit ends up in bit 0.
    always_comb begin
        shift_in                = shift_q >> 1;
        shift_in[DATA_BITS-1]   = rx_s;
    end

    assign o_busy = (state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift_q     <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) state <= ST_START;
                end
                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shift_q <= shift_in;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            state   <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            o_data  <= shift_q;
                            o_valid <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= ST_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // Break or stuck-low line: hold off until the line idles.
                ST_WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) state <= ST_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, the receive-side counterpart of the existing uart_tx.
- Takes the asynchronous serial line, synchronizes it, detects and qualifies the start bit, samples DATA_BITS data bits LSB-first at mid-bit, and checks the stop bit.
- Presents each received word with a one-cycle valid strobe.
- Sits between the board RX pin and the Wishbone UART register block.

Parameters:
- CLOCK_RATE, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- DATA_BITS, 8, data bits per frame (1..8); no parity bit.
- CYCLES_PER_BIT, (CLOCK_RATE/BAUD_RATE)-1, terminal count of the bit counter. Bit period = CYCLES_PER_BIT+1 clocks. Must match uart_tx.

Ports:
- i_clk  input  1  system clock, all logic on posedge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_rx  input  1  raw serial line, idle high, asynchronous to i_clk.
- o_data  output  DATA_BITS  last correctly framed word; held until the next good frame.
- o_valid  output  1  one-cycle pulse when o_data updates.
- o_frame_err  output  1  one-cycle pulse when the stop bit samples low.
- o_busy  output  1  high whenever state != ST_IDLE.

Behaviour:
- Clock and reset: one clock (i_clk); reset i_rst_n is asynchronous, active-low.
- Reset values: o_data=0, o_valid=0, o_frame_err=0, o_busy=0, state=ST_IDLE, counters=0, synchronizer flops=1 (line idle).
- Reset mid-frame: aborts immediately. No valid or error pulse follows deassertion.
- Synchronizer: 2-flop, output rx_s. All decisions use rx_s only, never i_rx.
- HALF = (CYCLES_PER_BIT+1)/2, integer division.
- Baud counter:
  - width $clog2(CYCLES_PER_BIT+1);
  - cleared on every state entry;
  - counts 0..CYCLES_PER_BIT and wraps to 0.
- Bit index: width $clog2(DATA_BITS+1).
- ST_IDLE:
  - counter held at 0;
  - rx_s==0 -> ST_START.
- ST_START:
  - when counter==HALF-1, check rx_s;
  - rx_s==1 is a glitch -> ST_IDLE, no pulses;
  - rx_s==0 -> ST_DATA, counter cleared. This places later samples at mid-bit.
- ST_DATA:
  - on each counter==CYCLES_PER_BIT, shift rx_s into the MSB of the shift register (LSB-first reception) and increment the bit index;
  - after the DATA_BITS-th sample -> ST_STOP.
- ST_STOP: on counter==CYCLES_PER_BIT, sample rx_s.
  - rx_s==1: next cycle o_data<=shift register, o_valid=1 for one cycle, -> ST_IDLE.
  - rx_s==0: next cycle o_frame_err=1 for one cycle, o_data unchanged, -> ST_WAIT_IDLE.
- ST_WAIT_IDLE:
  - covers break and line stuck low;
  - stays until rx_s==1, then -> ST_IDLE;
  - no new frame is accepted until then.
- Latency: o_valid asserts 1 clock after the mid-stop-bit sample, which is about 2 sync cycles + HALF + (DATA_BITS+1)*(CYCLES_PER_BIT+1) clocks after the falling edge of the start bit.
- Pulses: o_valid and o_frame_err are never high together; neither is high two consecutive cycles.
- Back-to-back frames: a start edge arriving in the cycle the FSM returns to ST_IDLE is detected the following cycle. The half-bit margin absorbs this.
- Unused state encodings return to ST_IDLE.

Decomposition:
- Shared package uart_pkg:
  - 3-bit state encodings ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_IDLE;
  - a cycles_per_bit(clock, baud) function, so that uart_tx and uart_rx compute the timing identically.
- Sub-module uart_sync: 2-flop synchronizer with async active-low reset, parameterizable reset value (1 here). Reused later for CTS.

Test Plan (CLOCK_RATE=1600000, BAUD_RATE=100000 -> CYCLES_PER_BIT=15, 16 clk/bit, HALF=8):
- Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> exactly one o_valid pulse with o_data=0xA5; o_frame_err stays 0; o_busy returns low.
- uart_tx loopback, bytes 0x00, 0xFF, 0x55, sent back-to-back with no idle gap -> three o_valid pulses, data in order, no framing errors.
- 5-clock low glitch on idle line -> o_busy high then low within about 10 clocks; no o_valid, no o_frame_err.
- Frame 0x3C with stop bit driven 0, line then held low 40 clocks before release -> o_frame_err single pulse; o_data keeps its previous value; next frame 0x81 is received correctly only after release.
- Assert i_rst_n low for 3 clocks mid-data-bit 4 of frame 0x7E -> all outputs 0 immediately; no pulse after release; next frame 0x12 is received correctly.
- Baud skew: ±3% bit-period error on 0xC3 -> received as 0xC3 with no error.
